// File: rtl/regfile_wport_arbiter.sv
// Write-port arbiter for the 32x32 integer register file.
// Shares the single write port between the in-order WB stage and an
// out-of-order multi-cycle unit. It keeps a pending-write scoreboard to stall
// ID on hazards, holds one completed result in a buffer, and stops WB from
// starving that buffered result.
module regfile_wport_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        wb_valid_i,
   input  logic [4:0]  wb_rd_addr_i,
   input  logic [31:0] wb_rd_wdata_i,
   input  logic        mc_issue_i,
   input  logic [4:0]  mc_issue_rd_i,
   input  logic        mc_done_valid_i,
   input  logic [4:0]  mc_done_rd_i,
   input  logic [31:0] mc_done_wdata_i,
   output logic        mc_done_ready_o,
   input  logic [4:0]  id_rs1_addr_i,
   input  logic [4:0]  id_rs2_addr_i,
   input  logic [4:0]  id_rd_addr_i,
   input  logic        id_rd_write_i,
   output logic        id_stall_o,
   output logic        wb_hold_o,
   output logic        rf_we_o,
   output logic [4:0]  rf_waddr_o,
   output logic [31:0] rf_wdata_o,
   output logic        err_o
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [31:0] pending_q, pending_d;
   logic        buf_valid_q, buf_valid_d;
   logic [4:0]  buf_rd_q, buf_rd_d;
   logic [31:0] buf_wdata_q, buf_wdata_d;
   logic [3:0]  starve_q, starve_d;
   logic        err_q, err_d;

   logic wb_owns;
   logic commit;
   logic done_hs;
   logic issue_conflict;

   // Write-port arbitration and status outputs; WB (rd!=0) always wins.
   always_comb begin
      // NOTE: every output gets a default first, so no path through the block
      // leaves a signal unassigned and no latch is inferred.
      rf_we_o         = 1'b0;
      rf_waddr_o      = '0;
      rf_wdata_o      = '0;
      wb_owns         = wb_valid_i && (wb_rd_addr_i != 5'd0);
      commit          = buf_valid_q && !wb_owns;
      mc_done_ready_o = !buf_valid_q;
      done_hs         = mc_done_valid_i && !buf_valid_q;
      wb_hold_o       = (starve_q == LIMIT);
      err_o           = err_q;

      if (wb_owns) begin
         rf_we_o    = 1'b1;
         rf_waddr_o = wb_rd_addr_i;
         rf_wdata_o = wb_rd_wdata_i;
      end else if (buf_valid_q) begin
         rf_we_o    = 1'b1;
         rf_waddr_o = buf_rd_q;
         rf_wdata_o = buf_wdata_q;
      end

      // Registered scoreboard: the stall persists through the commit cycle.
      id_stall_o = (pending_q[id_rs1_addr_i] && (id_rs1_addr_i != 5'd0)) ||
                   (pending_q[id_rs2_addr_i] && (id_rs2_addr_i != 5'd0)) ||
                   (id_rd_write_i && pending_q[id_rd_addr_i] && (id_rd_addr_i != 5'd0));
   end

   // Next-state for scoreboard, result buffer, starve counter and error flag.
   always_comb begin
      pending_d   = pending_q;
      buf_valid_d = buf_valid_q;
      buf_rd_d    = buf_rd_q;
      buf_wdata_d = buf_wdata_q;
      starve_d    = starve_q;
      err_d       = err_q;

      // Clear first so that a same-cycle issue to the committing rd wins.
      if (commit) begin
         pending_d[buf_rd_q] = 1'b0;
         buf_valid_d         = 1'b0;
         starve_d            = '0;
      end else if (buf_valid_q && wb_owns && (starve_q != LIMIT)) begin
         starve_d = starve_q + 4'd1;
      end

      if (mc_issue_i && (mc_issue_rd_i != 5'd0)) begin
         pending_d[mc_issue_rd_i] = 1'b1;
      end

      // A result to x0 is accepted and dropped.
      if (done_hs && (mc_done_rd_i != 5'd0)) begin
         buf_valid_d = 1'b1;
         buf_rd_d    = mc_done_rd_i;
         buf_wdata_d = mc_done_wdata_i;
      end

      // Reissuing the rd that is committing this very cycle is legal.
      issue_conflict = mc_issue_i && (mc_issue_rd_i != 5'd0) &&
                       pending_q[mc_issue_rd_i] &&
                       !(commit && (buf_rd_q == mc_issue_rd_i));

      if ((wb_valid_i && wb_hold_o) ||
          (wb_valid_i && pending_q[wb_rd_addr_i]) ||
          (done_hs && (mc_done_rd_i != 5'd0) && !pending_q[mc_done_rd_i]) ||
          issue_conflict) begin
         err_d = 1'b1;
      end
   end

   // State registers; everything, including buffer contents, is cleared on reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending_q   <= '0;
         buf_valid_q <= 1'b0;
         buf_rd_q    <= '0;
         buf_wdata_q <= '0;
         starve_q    <= '0;
         err_q       <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         pending_q   <= pending_d;
         buf_valid_q <= buf_valid_d;
         buf_rd_q    <= buf_rd_d;
         buf_wdata_q <= buf_wdata_d;
         starve_q    <= starve_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: doc/regfile_wport_arbiter.md
# regfile_wport_arbiter

Owns the single write port of the 32x32 integer register file and shares it between the in-order WB stage and a long-latency multi-cycle unit (divider/load return path) that completes out of order. It keeps a 32-bit pending-write scoreboard and stalls ID on RAW/WAW hazards against in-flight multi-cycle results. It buffers one completed result and prevents WB from starving that result. It sits between WB, the multi-cycle unit, ID hazard logic and the register file write port (A3/WD3/WE3).

## Interface
- STARVE_LIMIT, 4: blocked-buffer cycles before `wb_hold_o` asserts (1..15).
- clk_i  in  1  clock; all state updates on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- wb_valid_i / wb_rd_addr_i / wb_rd_wdata_i  in  1/5/32  WB write request; never back-pressured.
- mc_issue_i / mc_issue_rd_i  in  1/5  multi-cycle op dispatched with destination rd.
- mc_done_valid_i / mc_done_rd_i / mc_done_wdata_i  in  1/5/32  multi-cycle result.
- mc_done_ready_o  out  1  result accepted when valid & ready.
- id_rs1_addr_i / id_rs2_addr_i / id_rd_addr_i / id_rd_write_i  in  5/5/5/1  ID-stage operands.
- id_stall_o  out  1  ID must hold (hazard on pending register).
- wb_hold_o  out  1  WB must present no write this cycle.
- rf_we_o / rf_waddr_o / rf_wdata_o  out  1/5/32  register file write port.
- err_o  out  1  sticky protocol-violation flag.

## Operation
- State: `pending[31:0]`, one-entry result buffer (`buf_valid`, `buf_rd`, `buf_wdata`), starve counter (4 bit), `err`.
- Reset values: pending=0, buf_valid=0, counter=0, err=0. After reset: mc_done_ready_o=1, rf_we_o=0, id_stall_o=0, wb_hold_o=0, err_o=0.
- Scoreboard set: `mc_issue_i` with rd≠0 sets `pending[rd]`. rd=0 never marks.
- Scoreboard clear: a buffer commit clears `pending[buf_rd]`. If an issue to the same rd occurs in the same cycle, set wins.
- Buffer: `mc_done_ready_o = !buf_valid`. A handshake loads the buffer. A result with rd=0 is accepted and discarded (buffer not loaded).
- Write-port arbitration, combinational:
  - WB has priority: if `wb_valid_i` and `wb_rd_addr_i`≠0, the port is driven from WB.
  - Otherwise, if `buf_valid`, the port is driven from the buffer (commit). buf_valid clears at the edge.
  - Otherwise `rf_we_o`=0.
  - WB with rd=0 does not occupy the port.
- Stall: `id_stall_o` = (pending[rs1] & rs1≠0) | (pending[rs2] & rs2≠0) | (id_rd_write_i & pending[rd] & rd≠0). Uses registered pending, so stall persists through the commit cycle.
- Starvation:
  - The counter increments each cycle the buffer is valid but blocked by WB, saturating at STARVE_LIMIT. It clears on commit.
  - `wb_hold_o` = (counter == STARVE_LIMIT).
  - WB must drop `wb_valid_i` while hold is high, which lets the buffer commit that cycle.
- err_o sets (sticky until reset) on any of:
  - `wb_valid_i` while `wb_hold_o` is high;
  - WB write to an rd with pending set;
  - result handshake for an rd (≠0) whose pending bit is 0;
  - `mc_issue_i` to an rd already pending.

## Timing
- Result handshake in cycle N → buffer valid N+1 → commit in N+1 if the port is free; the regfile is written at the end of N+1.
- pending clears at the N+1/N+2 edge. id_stall_o drops in N+2, and the combinational regfile read returns the new value in N+2.
- Issue in cycle N → stall on that rd visible from N+1.
- Maximum buffer latency under continuous WB traffic: STARVE_LIMIT+1 cycles.
- Reset mid-operation (asynchronous): buffer contents and pending bits are lost; outputs return to reset values immediately.

## Test plan
- Reset with rst_ni low mid-buffer → all outputs at reset values; mc_done_ready_o=1; pending cleared.
- Basic flow, STARVE_LIMIT=4:
  - Issue rd=5 at cycle 0, with ID rs1=5 from cycle 1 → id_stall_o=1.
  - Result 0xDEADBEEF handshakes at cycle 10 with WB idle → rf_we_o=1, addr 5, data 0xDEADBEEF at cycle 11.
  - id_stall_o=0 at cycle 12.
- Collision: buffer valid for rd=7 with WB writing rd=3 continuously → WB wins; wb_hold_o=1 after 4 blocked cycles. WB drops valid → buffer commits rd=7 that cycle; counter returns to 0.
- Same-cycle issue to rd=9 while buffer commits rd=9 → regfile written; pending[9] remains 1; stall holds for rs2=9.
- rd=0 cases: issue rd=0 and result rd=0 → no pending, no rf_we_o, no stall, err_o=0. WB with rd=0 does not block the buffer.
- Violations:
  - WB write to a pending rd → err_o=1, sticky until reset.
  - Result for a non-pending rd=12 → err_o=1.
